// File: rtl/ifetch_align.sv
// ifetch_align: instruction-fetch front end that realigns RV32IC instructions on halfword boundaries.
// Ports: clk/rst_n (sync active-low reset); imem_addr/imem_dout (1-cycle-latency word memory);
// redirect_valid/redirect_pc (new fetch target, flushes buffered data);
// out_valid/out_ready/out_instr/out_pc/out_compressed (one instruction per handshake to decode).
module ifetch_align #(
  parameter int ADDR_WIDTH = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  output logic                  out_compressed
);
  logic [31:0] pc, q0, q1;
  logic [1:0] count, occ, slot;
  logic inflight, hp, straddle, comp, xfer, pop, issue;
  always_comb begin
    straddle = hp && q0[17:16] == 2'b11;
    comp = hp ? !straddle : q0[1:0] != 2'b11;
    out_valid = count != 2'd0 && (!straddle || count == 2'd2);
    xfer = out_valid && out_ready;
    // hp=0 C leaves the head word for its upper half; every other case consumes the head
    pop = xfer && (hp || !comp);
    slot = count - {1'b0, pop};
    // occupancy once this cycle's pop and in-flight push settle; a new request fits only below 2
    occ = slot + {1'b0, inflight};
    issue = occ < 2'd2;
    out_compressed = out_valid && comp;
    out_pc = pc;
    out_instr = !out_valid ? 32'h0 :
                straddle ? {q1[15:0], q0[31:16]} :
                !comp ? q0 : {16'h0, hp ? q0[31:16] : q0[15:0]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_addr <= RESET_PC[ADDR_WIDTH+1:2];
      pc <= RESET_PC & 32'hffff_fffe;
      hp <= RESET_PC[1];
      count <= 2'd0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      imem_addr <= redirect_pc[ADDR_WIDTH+1:2];
      pc <= redirect_pc & 32'hffff_fffe;
      hp <= redirect_pc[1];
      count <= 2'd0;
      inflight <= 1'b0;
    end else begin
      if (issue) imem_addr <= imem_addr + ADDR_WIDTH'(1);
      inflight <= issue;
      count <= occ;
      if (xfer) begin
        pc <= pc + (comp ? 32'd2 : 32'd4);
        hp <= comp ? !hp : hp;
      end
      if (inflight && slot == 2'd0) q0 <= imem_dout;
      else if (pop) q0 <= q1;
      if (inflight && slot == 2'd1) q1 <= imem_dout;
    end
  end
endmodule

// File: tb/tb_ifetch_align.sv
// tb_ifetch_align: directed and randomized checks of ifetch_align against a halfword-stream model.
module tb_ifetch_align;
  logic clk, rst_n, redirect_valid, out_ready, out_valid, out_compressed;
  logic [8:0] imem_addr;
  logic [31:0] imem_dout, redirect_pc, out_instr, out_pc;
  logic [31:0] mem [512];
  int checks = 0, errs = 0;

  ifetch_align dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_compressed(out_compressed)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) imem_dout <= mem[imem_addr];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  // model: the instruction stream is just the program's halfwords read in PC order
  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[10:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction
  function automatic logic is_c(input logic [31:0] a);
    logic [15:0] h;
    h = half(a);
    return h[1:0] != 2'b11;
  endfunction
  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    return is_c(a) ? {16'h0, half(a)} : {half(a + 32'd2), half(a)};
  endfunction

  logic [31:0] m_pc, p_instr, p_pc;
  logic p_c, hold, started = 0;
  int since = 0;
  logic [31:0] lg_i[$], lg_p[$];
  logic lg_c[$];

  always @(negedge clk) begin
    if (started && rst_n) begin
      chk("pc", out_pc, m_pc);
      chk("qdepth_le2", 32'(dut.count <= 2'd2), 1);
      if (since < 2) chk("early_valid", 32'(out_valid), 0);
      if (since == 2) chk("tgt_valid", 32'(out_valid), 32'(!(m_pc[1] && !is_c(m_pc))));
      if (since == 3) chk("tgt_valid3", 32'(out_valid), 1);
      if (out_valid) begin
        chk("instr", out_instr, exp_instr(m_pc));
        chk("compressed", 32'(out_compressed), 32'(is_c(m_pc)));
      end else begin
        chk("idle_instr", out_instr, 0);
        chk("idle_c", 32'(out_compressed), 0);
      end
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_instr", out_instr, p_instr);
        chk("hold_pc", out_pc, p_pc);
        chk("hold_c", 32'(out_compressed), 32'(p_c));
      end
    end
    hold = started && rst_n && out_valid && !out_ready && !redirect_valid;
    p_instr = out_instr;
    p_pc = out_pc;
    p_c = out_compressed;
    if (!rst_n) begin
      started = 1;
      m_pc = 32'h0;
      since = 0;
    end else if (started) begin
      if (out_valid && out_ready) begin
        lg_i.push_back(out_instr);
        lg_p.push_back(out_pc);
        lg_c.push_back(out_compressed);
      end
      if (redirect_valid) begin
        m_pc = redirect_pc & 32'hffff_fffe;
        since = 0;
      end else begin
        if (out_valid && out_ready) m_pc = m_pc + (is_c(m_pc) ? 32'd2 : 32'd4);
        since++;
      end
    end
  end

  task automatic start_rst();
    @(posedge clk);
    #1 rst_n = 0;
    redirect_valid = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  endtask
  task automatic end_rst();
    @(posedge clk);
    #1 rst_n = 1;
    lg_i.delete();
    lg_p.delete();
    lg_c.delete();
  endtask
  task automatic chk_entry(input string n, input int k, input logic [31:0] i, input logic [31:0] p, input logic c);
    if (lg_i.size() <= k) begin
      chk({n, "_missing"}, lg_i.size(), k + 1);
    end else begin
      chk({n, "_instr"}, lg_i[k], i);
      chk({n, "_pc"}, lg_p[k], p);
      chk({n, "_c"}, 32'(lg_c[k]), 32'(c));
    end
  endtask

  initial begin
    rst_n = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    out_ready = 1;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    // reset / aligned stream and startup latency
    start_rst();
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    for (int i = 2; i < 20; i++) mem[i] = 32'h0000_0013;
    out_ready = 1;
    end_rst();
    @(posedge clk);
    @(negedge clk) chk("t1_e1_valid", 32'(out_valid), 0);
    @(posedge clk);
    @(negedge clk) chk("t1_e2_valid", 32'(out_valid), 1);
    chk("t1_e2_instr", out_instr, 32'h0000_0013);
    chk("t1_e2_pc", out_pc, 0);
    repeat (9) @(negedge clk);
    #1 chk("t1_throughput", lg_i.size(), 10);
    chk_entry("t1_0", 0, 32'h0000_0013, 32'h0, 0);
    chk_entry("t1_1", 1, 32'h0010_0093, 32'h4, 0);
    // compressed pair
    start_rst();
    mem[0] = 32'h4001_4001;
    mem[1] = 32'h0010_0093;
    end_rst();
    repeat (7) @(negedge clk);
    #1 chk_entry("t2_0", 0, 32'h0000_4001, 32'h0, 1);
    chk_entry("t2_1", 1, 32'h0000_4001, 32'h2, 1);
    chk_entry("t2_2", 2, 32'h0010_0093, 32'h4, 0);
    // straddle
    start_rst();
    mem[0] = 32'h0093_4001;
    mem[1] = 32'h4001_0010;
    end_rst();
    repeat (8) @(negedge clk);
    #1 chk_entry("t3_0", 0, 32'h0000_4001, 32'h0, 1);
    chk_entry("t3_1", 1, 32'h0010_0093, 32'h2, 0);
    chk_entry("t3_2", 2, 32'h0000_4001, 32'h6, 1);
    // backpressure
    start_rst();
    for (int i = 0; i < 512; i++) mem[i] = (i << 7) | 32'h13;
    end_rst();
    repeat (5) @(posedge clk);
    #1 out_ready = 0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1;
    repeat (10) @(negedge clk);
    #1 chk("t4_count", 32'(lg_i.size() >= 10), 1);
    for (int k = 0; k < lg_i.size(); k++) chk_entry("t4_seq", k, (k << 7) | 32'h13, 32'(k * 4), 0);
    // redirect with a word in flight
    start_rst();
    for (int i = 0; i < 4; i++) mem[i] = 32'h0000_0013;
    mem[64] = 32'h4001_4001;
    end_rst();
    repeat (3) @(posedge clk);
    #1 redirect_valid = 1;
    redirect_pc = 32'h0000_0102;
    @(posedge clk);
    #1 redirect_valid = 0;
    chk("t5_addr", 32'(imem_addr), 64);
    @(negedge clk) chk("t5_n0_valid", 32'(out_valid), 0);
    @(posedge clk);
    @(negedge clk) chk("t5_n1_valid", 32'(out_valid), 0);
    @(posedge clk);
    @(negedge clk) chk("t5_n2_valid", 32'(out_valid), 1);
    chk("t5_instr", out_instr, 32'h0000_4001);
    chk("t5_pc", out_pc, 32'h0000_0102);
    chk("t5_c", 32'(out_compressed), 1);
    // reset mid-operation with a full queue
    start_rst();
    for (int i = 0; i < 512; i++) mem[i] = (i << 7) | 32'h13;
    out_ready = 0;
    end_rst();
    repeat (6) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    chk("t6_addr", 32'(imem_addr), 0);
    @(negedge clk) chk("t6_e0_valid", 32'(out_valid), 0);
    @(posedge clk);
    @(negedge clk) chk("t6_e1_valid", 32'(out_valid), 0);
    @(posedge clk);
    @(negedge clk) chk("t6_e2_valid", 32'(out_valid), 1);
    chk("t6_instr", out_instr, 32'h0000_0013);
    // randomized stream with backpressure, redirects (one across the wrap) and resets
    start_rst();
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[511][17:16] = 2'b11;
    out_ready = 1;
    end_rst();
    repeat (4) @(posedge clk);
    #1 redirect_valid = 1;
    redirect_pc = 32'h0000_07fe;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1 out_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 39) == 0;
      redirect_pc = $urandom;
      rst_n = $urandom_range(0, 499) != 0;
    end
    #1 rst_n = 1;
    redirect_valid = 0;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
